alu_word_sequencer: RTL and testbench

//  Multi-word sequencer for the SIZE-bit ALU. It accepts one WORDS*SIZE-bit operation

---
 rtl/alu_word_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_word_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_word_sequencer.sv
// Multi-word sequencer: splits one WORDS*SIZE-bit operation into SIZE-bit ALU
// passes, LSB word first, chaining the carry and assembling the wide result.
module alu_word_sequencer #(
    parameter int SIZE  = 8,
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [2:0]            op,
    input  logic                  carry_in,
    input  logic [SIZE*WORDS-1:0] operand_a,
    input  logic [SIZE*WORDS-1:0] operand_b,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [SIZE*WORDS-1:0] result,
    output logic                  carry_out,
    output logic                  busy,
    output logic                  alu_ce,
    output logic [2:0]            alu_op,
    output logic [SIZE-1:0]       alu_left,
    output logic [SIZE-1:0]       alu_right,
    output logic                  alu_carry_in,
    input  logic [SIZE-1:0]       alu_op_out,
    input  logic                  alu_carry_out
);

    localparam int W     = SIZE * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    // Shared OP_CODES encoding: ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOT=5 LD=6 ST=7.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [2:0]       op_reg;
    logic [W-1:0]     a_reg, b_reg;
    logic [IDX_W-1:0] idx;
    logic             chain_carry;
    logic             arith;
    logic [SIZE-1:0]  b_word;

    assign arith  = (op_reg == OP_ADD) || (op_reg == OP_SUB);
    assign b_word = b_reg[idx*SIZE +: SIZE];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        alu_ce       = 1'b0;
        alu_op       = '0;
        alu_left     = '0;
        alu_right    = '0;
        alu_carry_in = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_next = RUN;
            end
            RUN: begin
                busy         = 1'b1;
                alu_ce       = 1'b1;
                alu_op       = arith ? OP_ADD : op_reg;
                alu_left     = a_reg[idx*SIZE +: SIZE];
                // Subtraction is a + ~b + 1 through the ALU add path.
                alu_right    = (op_reg == OP_SUB) ? ~b_word : b_word;
                alu_carry_in = arith & chain_carry;
                if (idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            idx         <= '0;
            chain_carry <= 1'b0;
            result      <= '0;
            carry_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        op_reg      <= op;
                        a_reg       <= operand_a;
                        b_reg       <= operand_b;
                        idx         <= '0;
                        result      <= '0;
                        carry_out   <= 1'b0;
                        chain_carry <= (op == OP_ADD) ? carry_in : (op == OP_SUB);
                    end
                end
                RUN: begin
                    result[idx*SIZE +: SIZE] <= alu_op_out;
                    chain_carry              <= alu_carry_out;
                    if (idx == LAST_IDX) begin
                        carry_out <= arith & alu_carry_out;
                        idx       <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer (SIZE=8, WORDS=2) with a behavioural
// ALU model attached; each task drives one scenario and checks it inline.
module tb_alu_word_sequencer;

    localparam int SIZE  = 8;
    localparam int WORDS = 2;
    localparam int W     = SIZE * WORDS;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                           OP_XOR = 3'd4, OP_NOT = 3'd5, OP_LD = 3'd6, OP_ST = 3'd7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [2:0]      op = '0;
    logic            carry_in = 1'b0;
    logic [W-1:0]    operand_a = '0;
    logic [W-1:0]    operand_b = '0;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [W-1:0]    result;
    logic            carry_out;
    logic            busy;
    logic            alu_ce;
    logic [2:0]      alu_op;
    logic [SIZE-1:0] alu_left, alu_right;
    logic            alu_carry_in;
    logic [SIZE-1:0] alu_op_out;
    logic            alu_carry_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_word_sequencer #(.SIZE(SIZE), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .carry_in(carry_in), .operand_a(operand_a), .operand_b(operand_b),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .carry_out(carry_out), .busy(busy),
        .alu_ce(alu_ce), .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
        .alu_carry_in(alu_carry_in), .alu_op_out(alu_op_out), .alu_carry_out(alu_carry_out)
    );

    // ALU model; logic ops report carry=1 so that a sequencer leaking it is caught.
    always_comb begin
        alu_op_out    = '0;
        alu_carry_out = 1'b1;
        case (alu_op)
            OP_ADD:  {alu_carry_out, alu_op_out} = {1'b0, alu_left} + {1'b0, alu_right}
                                                   + {{SIZE{1'b0}}, alu_carry_in};
            OP_SUB:  {alu_carry_out, alu_op_out} = {1'b0, alu_left} - {1'b0, alu_right};
            OP_AND:  alu_op_out = alu_left & alu_right;
            OP_OR:   alu_op_out = alu_left | alu_right;
            OP_XOR:  alu_op_out = alu_left ^ alu_right;
            OP_NOT:  alu_op_out = ~alu_left;
            OP_LD:   alu_op_out = alu_right;
            default: alu_op_out = alu_left;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Issues one operation, checks acceptance and latency, then consumes the result.
    task automatic run_op(input string name, input logic [2:0] o, input logic cin,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_cout);
        int lat;
        cmp({name, " start_ready"}, W'(start_ready), W'(1));
        start_valid = 1'b1; op = o; carry_in = cin; operand_a = a; operand_b = b;
        tick();
        start_valid = 1'b0;
        cmp({name, " alu_ce in RUN"}, W'(alu_ce), W'(1));
        lat = 0;
        do begin
            tick();
            lat++;
        end while (result_valid !== 1'b1 && lat < 8);
        cmp({name, " latency"}, W'(lat), W'(WORDS));
        cmp({name, " result"}, result, exp_res);
        cmp({name, " carry_out"}, W'(carry_out), W'(exp_cout));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        cmp({name, " back to IDLE"}, W'({start_ready, result_valid, busy}), W'(3'b100));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cmp("reset ready/valid/busy", W'({start_ready, result_valid, busy}), W'(3'b100));
        cmp("reset result", result, '0);
        cmp("reset carry_out", W'(carry_out), '0);
        cmp("reset alu drive", W'({alu_ce, alu_op, alu_left, alu_carry_in}), '0);
        cmp("reset alu_right", W'(alu_right), '0);
    endtask

    task automatic test_add();
        run_op("add 00FF+0001", OP_ADD, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0);
        run_op("add FFFF+0001", OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        run_op("add 0+0+cin",   OP_ADD, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0);
    endtask

    task automatic test_sub();
        run_op("sub 0100-0001", OP_SUB, 1'b0, 16'h0100, 16'h0001, 16'h00FF, 1'b1);
        run_op("sub 0001-0002", OP_SUB, 1'b1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0);
    endtask

    task automatic test_logic();
        run_op("xor", OP_XOR, 1'b1, 16'hA5F0, 16'hFF0F, 16'h5AFF, 1'b0);
        run_op("not", OP_NOT, 1'b0, 16'h1234, 16'h0000, 16'hEDCB, 1'b0);
        run_op("ld",  OP_LD,  1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0);
        run_op("and", OP_AND, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);
    endtask

    task automatic test_backpressure();
        start_valid = 1'b1; op = OP_ADD; carry_in = 1'b0;
        operand_a = 16'h1234; operand_b = 16'h1111;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        cmp("bp result_valid", W'(result_valid), W'(1));
        start_valid = 1'b1; operand_a = 16'hFFFF; operand_b = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp("bp held result", result, 16'h2345);
            cmp("bp ready/valid/busy", W'({start_ready, result_valid, busy}), W'(3'b011));
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        cmp("bp release to IDLE", W'({start_ready, result_valid, busy}), W'(3'b100));
        cmp("bp alu idle", W'({alu_ce, alu_op, alu_right}), '0);
    endtask

    task automatic test_reset_in_run();
        start_valid = 1'b1; op = OP_ADD; carry_in = 1'b1;
        operand_a = 16'hAAAA; operand_b = 16'h5555;
        tick();
        start_valid = 1'b0;
        cmp("rr in RUN", W'(alu_ce), W'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cmp("rr ready/valid/busy", W'({start_ready, result_valid, busy}), W'(3'b100));
        cmp("rr alu_ce", W'(alu_ce), '0);
        cmp("rr result", result, '0);
        run_op("add after reset", OP_ADD, 1'b0, 16'h0F0F, 16'h0101, 16'h1010, 1'b0);
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_backpressure();
        test_reset_in_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
